// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for handshaked pipeline stage registers: FSM state encoding and stage payloads.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_MAIN,
        PS_SKID
    } pipe_state_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH
    } op_t;

    // id->ex payload; instantiate the buffer with WIDTH = $bits(id_ex_payload_t).
    typedef struct packed {
        op_t         op;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic        reg_we;
        logic [4:0]  reg_waddr;
    } id_ex_payload_t;

    localparam int unsigned OCC_W = 2;

    function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_t s);
        logic [OCC_W-1:0] occ;
        occ = 2'd0;
        case (s)
            PS_MAIN: occ = 2'd1;
            PS_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear; used for back-pressure and other perf counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid-buffered pipeline stage register with flush, bubble injection and
// a saturating back-pressure counter. in_ready comes straight from a flop.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned     WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int unsigned     CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bp_count,
    input  logic             bp_clear
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign occupancy = state_occupancy(state_q);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Anything accepted this cycle is discarded; a concurrent out_fire was delivered.
            state_d = PS_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_d = PS_MAIN;
                        main_d  = in_data;
                    end
                end
                PS_MAIN: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = PS_SKID;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = PS_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                PS_SKID: begin
                    if (out_fire) begin
                        state_d = PS_MAIN;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
        in_ready_d = (state_d != PS_SKID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PS_EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bp_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_valid & ~out_ready),
        .clr  (bp_clear),
        .count(bp_count)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-based reference model plus directed and random stimulus.
module tb_pipe_stage_buf;

    localparam int unsigned     W     = 16;
    localparam int unsigned     CW    = 4;
    localparam logic [W-1:0]    BUB   = 16'hDEAD;
    localparam int unsigned     BPMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [1:0]    occupancy;
    logic [CW-1:0] bp_count;
    logic          bp_clear;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: payloads in flight, oldest first, and the expected stall count.
    logic [W-1:0] exp_q[$];
    int unsigned  bp_m;

    pipe_stage_buf #(
        .WIDTH (W),
        .BUBBLE(BUB),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .bp_count (bp_count),
        .bp_clear (bp_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model update on every accepted clock edge or asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                bp_m = 0;
            end else begin
                bit m_in_fire, m_out_fire;
                m_in_fire  = in_valid && (exp_q.size() < 2);
                m_out_fire = out_ready && (exp_q.size() > 0);
                if (bp_clear) bp_m = 0;
                else if ((exp_q.size() > 0) && !out_ready && (bp_m < BPMAX)) bp_m++;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (m_out_fire) void'(exp_q.pop_front());
                    if (m_in_fire) exp_q.push_back(in_data);
                end
            end
        end
    end

    // Monitor: compare what the DUT presents against the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) chk("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
            else chk("out_data_bubble", {16'd0, out_data}, {16'd0, BUB});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
            chk("occupancy", {30'd0, occupancy}, exp_q.size());
            chk("bp_count", {28'd0, bp_count}, bp_m);
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        @(negedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        bp_clear  = clr;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        bp_clear  = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        idle(1'b1, 3);

        // Back-to-back stream with a ready sink.
        drive(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Fill the skid entry under back-pressure, stall, then drain.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 5);
        idle(1'b1, 4);

        // Flush while full, with a new input offered in the same cycle.
        drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h000C, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Counter saturation, then clear while still stalled.
        drive(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 20);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 2);
        idle(1'b1, 2);

        // Asynchronous reset in the middle of the high phase while full.
        drive(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_out_data", {16'd0, out_data}, {16'd0, BUB});
        chk("areset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("areset_occupancy", {30'd0, occupancy}, 32'd0);
        chk("areset_bp_count", {28'd0, bp_count}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        // Randomised traffic with occasional flush and counter clear.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom_range(0, 16'hFFFF)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 63) == 0));
        end
        idle(1'b1, 4);

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
